// File: rtl/conv1_window_feeder.sv
// Sliding-window feeder for the layer-1 convolution. It frames FRAME_LEN samples per start
// and presents each TAPS-wide window with a valid/ready handshake.
module conv1_window_feeder #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned TAPS      = 5,
    parameter int unsigned FRAME_LEN = 187
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     s_ready,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [TAPS*DATA_W-1:0]   win_data,
    output logic                     conv_en,
    output logic [7:0]               win_idx,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int unsigned CntW = $clog2(FRAME_LEN + 1);
    localparam int unsigned WinW = TAPS * DATA_W;

    typedef enum logic [1:0] {StIdle, StFill, StRun, StFlush} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [WinW-1:0] shreg_q, shreg_d;
    logic [WinW-1:0] shifted;
    logic            win_valid_q, win_valid_d;
    logic [WinW-1:0] win_data_q, win_data_d;
    logic [7:0]      win_idx_q, win_idx_d;
    logic            done_q, done_d;
    logic            in_stream;
    logic            accept;
    logic            fire;

    // Oldest tap sits in the low bits; each new sample enters at the top.
    assign shifted   = {s_data, shreg_q[WinW-1:DATA_W]};

    assign in_stream = (state_q == StFill) || (state_q == StRun);
    assign s_ready   = in_stream && (!win_valid_q || win_ready);
    assign accept    = s_valid && s_ready;
    assign fire      = win_valid_q && win_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        win_idx_d   = win_idx_q;
        done_d      = 1'b0;

        if (fire) begin
            win_valid_d = 1'b0;
            win_idx_d   = win_idx_q + 8'd1;
        end

        // A load in the same cycle as a fire keeps the window valid with fresh data.
        if (accept) begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CntW'(1);
            if (state_q == StRun) begin
                win_data_d  = shifted;
                win_valid_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFill;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            StFill: begin
                if (accept && (cnt_q == CntW'(TAPS - 2))) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept && (cnt_q == CntW'(FRAME_LEN - 1))) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (fire) begin
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    win_idx_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shreg_q     <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            win_idx_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            win_idx_q   <= win_idx_d;
            done_q      <= done_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign win_idx    = win_idx_q;
    assign conv_en    = fire;
    assign busy       = (state_q != StIdle);
    assign frame_done = done_q;

endmodule

// File: tb/tb_conv1_window_feeder.sv
// Directed bench for conv1_window_feeder: ramp, backpressure, gaps, signed extremes and
// mid-frame async reset, each frame checked against windows built from the sample table.
module tb_conv1_window_feeder;

    localparam int FRAME = 187;
    localparam int TAPS  = 5;
    localparam int NWIN  = FRAME - TAPS + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              win_valid;
    logic              win_ready;
    logic [TAPS*8-1:0] win_data;
    logic              conv_en;
    logic [7:0]        win_idx;
    logic              busy;
    logic              frame_done;

    conv1_window_feeder #(
        .DATA_W    (8),
        .TAPS      (TAPS),
        .FRAME_LEN (FRAME)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .conv_en    (conv_en),
        .win_idx    (win_idx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]        samples [FRAME];
    int                n_fire, mism, stall_viol, spur_viol, acc_n;
    int                acc5_cyc, first_wv_cyc, first_acc_cyc, last_acc_cyc;
    int                last_fire_cyc, done_cyc;
    logic [TAPS*8-1:0] first_win, last_win;
    logic [7:0]        last_idx;
    int                mid_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TAPS*8-1:0] exp_win(input int k);
        logic [TAPS*8-1:0] w;
        for (int j = 0; j < TAPS; j++) w[j*8 +: 8] = samples[k+j];
        return w;
    endfunction

    // Entered and left at posedge+1.
    task automatic run_frame(input bit gaps, input bit bp, input bit mid_start);
        bit                prev_stall, prev_wv, prev_acc, cur_acc;
        logic [TAPS*8-1:0] held_data;
        logic [7:0]        held_idx;
        int                sidx;
        start = 1'b1; s_valid = 1'b0; win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 64'(busy), 64'(1));
        @(posedge clk); #1;
        n_fire = 0; mism = 0; stall_viol = 0; spur_viol = 0; acc_n = 0;
        acc5_cyc = -1; first_wv_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
        last_fire_cyc = -1; done_cyc = -1;
        prev_stall = 1'b0; prev_wv = 1'b0; prev_acc = 1'b0; sidx = 0;
        held_data = '0; held_idx = '0;
        for (int c = 0; c < 4000 && done_cyc < 0; c++) begin
            s_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            win_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data    = (sidx < FRAME) ? samples[sidx] : 8'h00;
            start     = mid_start && (c == 40);
            @(negedge clk);
            if (prev_stall && (win_data !== held_data || win_idx !== held_idx)) stall_viol++;
            if (win_valid && !prev_wv && !prev_acc) spur_viol++;
            if (win_valid && first_wv_cyc < 0) first_wv_cyc = c;
            if (frame_done) done_cyc = c;
            cur_acc = s_valid && s_ready;
            if (cur_acc) begin
                if (acc_n == 0) first_acc_cyc = c;
                acc_n++;
                if (acc_n == TAPS) acc5_cyc = c;
                last_acc_cyc = c;
                sidx++;
            end
            if (conv_en) begin
                if (n_fire >= NWIN) mism++;
                else if (win_data !== exp_win(n_fire) || win_idx !== 8'(n_fire)) mism++;
                if (n_fire == 0) first_win = win_data;
                last_win = win_data;
                last_idx = win_idx;
                last_fire_cyc = c;
                n_fire++;
            end
            prev_stall = win_valid && !win_ready;
            held_data  = win_data;
            held_idx   = win_idx;
            prev_wv    = win_valid;
            prev_acc   = cur_acc;
            @(posedge clk); #1;
        end
        start = 1'b0; s_valid = 1'b0;
        chk("fire_count", 64'(n_fire), 64'(NWIN));
        chk("window_order", 64'(mism), 64'(0));
        chk("stall_stable", 64'(stall_viol), 64'(0));
        chk("no_spurious_valid", 64'(spur_viol), 64'(0));
        chk("done_after_last_fire", 64'(done_cyc), 64'(last_fire_cyc + 1));
        @(negedge clk);
        chk("done_pulse_idle", 64'({frame_done, busy, win_idx}), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; win_ready = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            start = 1'($urandom_range(0, 1)); s_valid = 1'($urandom_range(0, 1));
            s_data = 8'($urandom); win_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("rst_ctrl", 64'({s_ready, win_valid, conv_en, win_idx, busy, frame_done}), 64'(0));
        chk("rst_win_data", 64'(win_data), 64'(0));

        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; s_valid = 1'b1; win_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_ready", 64'({s_ready, busy, win_valid}), 64'(0));
        @(posedge clk); #1;

        // Ramp, full throughput
        for (int i = 0; i < FRAME; i++) samples[i] = 8'(i + 1);
        run_frame(1'b0, 1'b0, 1'b0);
        chk("ramp_first_win", 64'(first_win), 64'({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}));
        chk("ramp_last_win", 64'(last_win), 64'({8'd187, 8'd186, 8'd185, 8'd184, 8'd183}));
        chk("ramp_last_idx", 64'(last_idx), 64'(182));
        chk("first_valid_latency", 64'(first_wv_cyc), 64'(acc5_cyc + 1));
        chk("last_fire_after_accept", 64'(last_fire_cyc), 64'(last_acc_cyc + 1));
        chk("frame_cycles", 64'(last_fire_cyc - first_acc_cyc), 64'(FRAME));

        // Backpressure, then input gaps, then both
        run_frame(1'b0, 1'b1, 1'b0);
        chk("bp_last_win", 64'(last_win), 64'({8'd187, 8'd186, 8'd185, 8'd184, 8'd183}));
        run_frame(1'b1, 1'b0, 1'b0);
        chk("gap_first_win", 64'(first_win), 64'({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}));
        run_frame(1'b1, 1'b1, 1'b0);

        // Signed extremes with a stray start mid-frame
        for (int i = 0; i < FRAME; i++) begin
            case (i % 5)
                0: samples[i] = 8'h80;
                1: samples[i] = 8'h7f;
                2: samples[i] = 8'hff;
                3: samples[i] = 8'h00;
                default: samples[i] = 8'h01;
            endcase
        end
        run_frame(1'b0, 1'b0, 1'b1);
        chk("ext_first_win", 64'(first_win), 64'({8'h01, 8'h00, 8'hff, 8'h7f, 8'h80}));
        chk("ext_last_win", 64'(last_win), 64'({8'h7f, 8'h80, 8'h01, 8'h00, 8'hff}));

        // Async reset after 50 ramp samples
        for (int i = 0; i < FRAME; i++) samples[i] = 8'(i + 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; win_ready = 1'b1;
        mid_cnt = 0;
        for (int c = 0; c < 200 && mid_cnt < 50; c++) begin
            s_data = samples[mid_cnt];
            @(negedge clk);
            if (s_valid && s_ready) mid_cnt++;
            @(posedge clk); #1;
        end
        chk("midrun_accepts", 64'(mid_cnt), 64'(50));
        chk("midrun_valid", 64'(win_valid), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("async_clear_ctrl",
            64'({s_ready, win_valid, conv_en, win_idx, busy, frame_done}), 64'(0));
        chk("async_clear_data", 64'(win_data), 64'(0));
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0;
        @(posedge clk); #1;
        run_frame(1'b0, 1'b0, 1'b0);
        chk("post_rst_first_win", 64'(first_win), 64'({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}));
        chk("post_rst_last_win", 64'(last_win), 64'({8'd187, 8'd186, 8'd185, 8'd184, 8'd183}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
